// File: rtl/hova_instr_deser.sv
// Hovalaag slow-bus instruction deserializer and output-bus sequencer.
// Optional build macro HOVA_DESER_ECHO_EN echoes instr[15:0] on io_out in stages 8/9.
// Purpose: assemble a 32-bit instruction from six 6-bit chunks and drive PC/OUT on the 8-bit bus.
// Latency: instr/instr_valid visible one cycle after the stage-5 chunk (start of stage 6).
// Backpressure: none on the bus; an unacked instruction is overwritten and flags sticky overrun.
module hova_instr_deser #(
    parameter int STAGES   = 10,
    parameter int CHUNK_W  = 6,
    parameter int INSTR_W  = 32,
    parameter int PC_STAGE = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [CHUNK_W-1:0] data_in,
    input  logic [7:0]         pc_next,
    input  logic [7:0]         out_val,
    input  logic               out_we,
    input  logic               instr_ack,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               overrun,
    output logic [3:0]         stage,
    output logic [7:0]         io_out
);

    localparam int NFULL  = INSTR_W / CHUNK_W;
    localparam int ASM_W  = NFULL * CHUNK_W;
    localparam int TAIL_W = INSTR_W - ASM_W;

    logic [3:0]         stage_q, stage_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               vld_q, vld_d;
    logic               ovr_q, ovr_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         out_q, out_d;

    always_comb begin
        stage_d = (stage_q == 4'(STAGES - 1)) ? 4'd0 : stage_q + 4'd1;
        asm_d   = asm_q;
        instr_d = instr_q;
        vld_d   = vld_q & ~instr_ack;
        ovr_d   = ovr_q;
        pc_d    = pc_q;
        out_d   = out_q;

        for (int k = 0; k < NFULL; k++) begin
            if (stage_q == 4'(k)) begin
                asm_d[k*CHUNK_W +: CHUNK_W] = data_in;
            end
        end

        // Tail stage: a pending unacked instruction is lost here, so flag it.
        if (stage_q == 4'(NFULL)) begin
            instr_d = {data_in[TAIL_W-1:0], asm_q};
            vld_d   = 1'b1;
            if (vld_q && !instr_ack) begin
                ovr_d = 1'b1;
            end
        end

        if (stage_q == 4'(PC_STAGE - 1)) begin
            pc_d = pc_next;
        end

        if (out_we) begin
            out_d = out_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q <= '0;
            asm_q   <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            pc_q    <= '0;
            out_q   <= '0;
        end else begin
            stage_q <= stage_d;
            asm_q   <= asm_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        io_out = out_q;
        if (stage_q == 4'(PC_STAGE)) begin
            io_out = pc_q;
        end
`ifdef HOVA_DESER_ECHO_EN
        else if (stage_q == 4'd8) begin
            io_out = instr_q[7:0];
        end else if (stage_q == 4'd9) begin
            io_out = instr_q[15:8];
        end
`endif
    end

    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign overrun     = ovr_q;
    assign stage       = stage_q;

endmodule
